dmem_channel_arbiter: RTL
=========================

// Module: dmem_channel_arbiter
// PURPOSE
//  Multiplexes NUM_CONSUMERS LSU read/write requests from the GPU cores onto NUM_CHANNELS external
//  data-memory channels. Sits between the cores' LSUs and the top-level data_mem_* ports.
//  Serves every consumer exactly once per request with valid/ready handshakes on both sides.
//  Grants use round-robin fairness.
// PARAMETERS
//  ADDR_BITS      8   data memory address width
//  DATA_BITS      8   data memory word width
//  NUM_CONSUMERS  8   requesting LSUs (NUM_CORES*THREADS_PER_BLOCK)
//  NUM_CHANNELS   4   external memory channels; 1 <= NUM_CHANNELS <= NUM_CONSUMERS
// PORTS
//  clk                    in   1                     clock; all logic on rising edge
//  reset                  in   1                     synchronous, active-high
//  consumer_read_valid    in   NUM_CONSUMERS         per-consumer read request
//  consumer_read_address  in   ADDR_BITS [NUM_CONSUMERS]      read address
//  consumer_read_ready    out  NUM_CONSUMERS         read data valid / request done
//  consumer_read_data     out  DATA_BITS [NUM_CONSUMERS]      returned read data
//  consumer_write_valid   in   NUM_CONSUMERS         per-consumer write request
//  consumer_write_address in   ADDR_BITS [NUM_CONSUMERS]      write address
//  consumer_write_data    in   DATA_BITS [NUM_CONSUMERS]      write data
//  consumer_write_ready   out  NUM_CONSUMERS         write done
//  mem_read_valid         out  NUM_CHANNELS          channel read request
//  mem_read_address       out  ADDR_BITS [NUM_CHANNELS]       channel read address
//  mem_read_ready         in   NUM_CHANNELS          memory read ack; data valid this cycle
//  mem_read_data          in   DATA_BITS [NUM_CHANNELS]       memory read data
//  mem_write_valid        out  NUM_CHANNELS          channel write request
//  mem_write_address      out  ADDR_BITS [NUM_CHANNELS]       channel write address
//  mem_write_data         out  DATA_BITS [NUM_CHANNELS]       channel write data
//  mem_write_ready        in   NUM_CHANNELS          memory write ack
// BEHAVIOUR
//  Reset: all outputs 0; every channel IDLE; claimed mask 0; rr_ptr 0. Reset mid-transaction aborts it silently.
//  Per-channel FSM: IDLE -> READ_WAITING | WRITE_WAITING -> READ_RELAYING | WRITE_RELAYING -> IDLE.
//  IDLE
//   - Pick the first consumer c, searching cyclically from rr_ptr, with (read_valid|write_valid) and not claimed.
//   - Channels evaluate in ascending index within one cycle; a consumer granted to a lower channel is
//     unavailable to higher ones in the same cycle.
//   - Grant: set claimed[c]; latch address/data into mem_*; assert mem_read_valid (read wins if both
//     asserted) or mem_write_valid. Next state *_WAITING.
//  rr_ptr: after any grant cycle, (last granted consumer + 1) mod NUM_CONSUMERS; otherwise unchanged.
//  *_WAITING
//   - Hold mem_*_valid/address/data stable until mem_*_ready=1.
//   - On that cycle: capture mem_read_data (read); drop mem_*_valid; set consumer_*_ready[c]=1
//     (read data driven same edge); go *_RELAYING.
//  *_RELAYING
//   - Hold consumer_*_ready[c]=1 and data until the consumer drops its *_valid.
//   - Then: ready=0, clear claimed[c], go IDLE. Earliest regrant of that channel is the next cycle.
//  Latency: grant 1 cycle after request seen; consumer ready 1 cycle after mem ready.
//  Minimum turnaround per request: 4 cycles with zero-wait memory.
//  Consumer valid dropped before completion (protocol violation): request completes anyway; ready
//   pulses 1 cycle, then IDLE.
//  mem ready while channel not WAITING: ignored.
//  All consumers requesting, NUM_CHANNELS channels free: exactly NUM_CHANNELS grants in one cycle.
//  NUM_CONSUMERS=NUM_CHANNELS: every request granted the cycle after it appears.
//  No consumer is ever served by two channels. No channel ever holds two consumers.
// TESTING
//  1. Single read: c3 reads addr 0x14, mem returns 26 after 5 cycles -> ch0 addr 0x14;
//     consumer_read_ready[3]=1, data 26, held until valid drops.
//  2. Single write: c5 writes 60 @0x19 -> mem_write_valid[0], addr 0x19, data 60;
//     write_ready[5] after ack; channel IDLE after valid drop.
//  3. All 8 consumers read addr=i simultaneously -> ch0..3 take c0..3 in one cycle, c4..7 after release.
//     Every consumer gets data i; no duplicate grants.
//  4. Fairness: c0 re-requests continuously, c1..7 once, NUM_CHANNELS=1 -> c1..7 each served before c0's second grant.
//  5. Reset asserted while ch2 in READ_WAITING -> next cycle all outputs 0.
//     Fresh request from same consumer served normally.
//  6. Mixed: c2 read and c6 write same cycle, mem ready same cycle on both channels -> both complete independently, correct data.

Source files
------------

// File: rtl/dmem_channel_arbiter_if.sv
// Bundles the LSU-side and memory-side request/response signals of the data-memory arbiter.
// The master modport is the arbiter's view; slave is the cores' and memory's view.
interface dmem_channel_arbiter_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4
);
    logic [NUM_CONSUMERS-1:0] consumer_read_valid;
    logic [ADDR_BITS-1:0]     consumer_read_address  [NUM_CONSUMERS];
    logic [NUM_CONSUMERS-1:0] consumer_read_ready;
    logic [DATA_BITS-1:0]     consumer_read_data     [NUM_CONSUMERS];
    logic [NUM_CONSUMERS-1:0] consumer_write_valid;
    logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS];
    logic [NUM_CONSUMERS-1:0] consumer_write_ready;

    logic [NUM_CHANNELS-1:0]  mem_read_valid;
    logic [ADDR_BITS-1:0]     mem_read_address  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  mem_read_ready;
    logic [DATA_BITS-1:0]     mem_read_data     [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  mem_write_valid;
    logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     mem_write_data    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  mem_write_ready;

    modport master (
        input  consumer_read_valid, consumer_read_address,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_read_ready, consumer_read_data, consumer_write_ready,
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );

    modport slave (
        output consumer_read_valid, consumer_read_address,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );
endinterface

// File: rtl/dmem_channel_arbiter.sv
// Round-robin arbiter that maps LSU read/write requests onto a set of data-memory channels,
// each channel running its own request -> memory wait -> consumer relay sequence.
module dmem_channel_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_channel_arbiter_if.master bus
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } state_t;

    state_t                   state [NUM_CHANNELS];
    logic [CW-1:0]            owner [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] claimed;
    logic [CW-1:0]            rr_ptr;

    logic                     grant_valid [NUM_CHANNELS];
    logic [CW-1:0]            grant_idx   [NUM_CHANNELS];
    logic                     any_grant;
    logic [CW-1:0]            last_grant;

    // Idle channels pick in ascending order; each pick is hidden from higher channels this cycle.
    always_comb begin
        logic [NUM_CONSUMERS-1:0] taken;
        logic [CW-1:0]            cand;
        taken      = claimed;
        cand       = '0;
        any_grant  = 1'b0;
        last_grant = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            grant_valid[ch] = 1'b0;
            grant_idx[ch]   = '0;
            if (state[ch] == IDLE) begin
                for (int i = 0; i < NUM_CONSUMERS; i++) begin
                    cand = CW'((int'(rr_ptr) + i) % NUM_CONSUMERS);
                    if (!grant_valid[ch] && !taken[cand] &&
                        (bus.consumer_read_valid[cand] || bus.consumer_write_valid[cand])) begin
                        grant_valid[ch] = 1'b1;
                        grant_idx[ch]   = cand;
                    end
                end
                if (grant_valid[ch]) begin
                    taken[grant_idx[ch]] = 1'b1;
                    any_grant            = 1'b1;
                    last_grant           = grant_idx[ch];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            claimed                  <= '0;
            rr_ptr                   <= '0;
            bus.consumer_read_ready  <= '0;
            bus.consumer_write_ready <= '0;
            bus.mem_read_valid       <= '0;
            bus.mem_write_valid      <= '0;
            for (int c = 0; c < NUM_CONSUMERS; c++) begin
                bus.consumer_read_data[c] <= {DATA_BITS{1'b0}};
            end
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state[ch]                 <= IDLE;
                owner[ch]                 <= '0;
                bus.mem_read_address[ch]  <= {ADDR_BITS{1'b0}};
                bus.mem_write_address[ch] <= {ADDR_BITS{1'b0}};
                bus.mem_write_data[ch]    <= {DATA_BITS{1'b0}};
            end
        end else begin
            if (any_grant) begin
                rr_ptr <= CW'((int'(last_grant) + 1) % NUM_CONSUMERS);
            end
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                unique case (state[ch])
                    IDLE: begin
                        if (grant_valid[ch]) begin
                            owner[ch]                <= grant_idx[ch];
                            claimed[grant_idx[ch]]   <= 1'b1;
                            // A consumer raising both requests is served as a read first.
                            if (bus.consumer_read_valid[grant_idx[ch]]) begin
                                bus.mem_read_valid[ch]   <= 1'b1;
                                bus.mem_read_address[ch] <= bus.consumer_read_address[grant_idx[ch]];
                                state[ch]                <= READ_WAITING;
                            end else begin
                                bus.mem_write_valid[ch]   <= 1'b1;
                                bus.mem_write_address[ch] <= bus.consumer_write_address[grant_idx[ch]];
                                bus.mem_write_data[ch]    <= bus.consumer_write_data[grant_idx[ch]];
                                state[ch]                 <= WRITE_WAITING;
                            end
                        end
                    end
                    READ_WAITING: begin
                        if (bus.mem_read_ready[ch]) begin
                            bus.mem_read_valid[ch]               <= 1'b0;
                            bus.consumer_read_ready[owner[ch]]   <= 1'b1;
                            bus.consumer_read_data[owner[ch]]    <= bus.mem_read_data[ch];
                            state[ch]                            <= READ_RELAYING;
                        end
                    end
                    WRITE_WAITING: begin
                        if (bus.mem_write_ready[ch]) begin
                            bus.mem_write_valid[ch]              <= 1'b0;
                            bus.consumer_write_ready[owner[ch]]  <= 1'b1;
                            state[ch]                            <= WRITE_RELAYING;
                        end
                    end
                    READ_RELAYING: begin
                        if (!bus.consumer_read_valid[owner[ch]]) begin
                            bus.consumer_read_ready[owner[ch]] <= 1'b0;
                            claimed[owner[ch]]                 <= 1'b0;
                            state[ch]                          <= IDLE;
                        end
                    end
                    WRITE_RELAYING: begin
                        if (!bus.consumer_write_valid[owner[ch]]) begin
                            bus.consumer_write_ready[owner[ch]] <= 1'b0;
                            claimed[owner[ch]]                  <= 1'b0;
                            state[ch]                           <= IDLE;
                        end
                    end
                    default: state[ch] <= IDLE;
                endcase
            end
        end
    end
endmodule
